toggle_event_counter: RTL

//   Counts the transitions of a T-latch output (Q) on the system clock, downstream
//   of the tlatch stage. Q is asynchronous to clk, so the block synchronises it,

---
 rtl/toggle_event_counter.sv | 108 ++++++++++
 1 files changed

// File: rtl/toggle_event_counter.sv
// Counts toggles of an asynchronous latch output: synchronises q_in, emits rise/fall
// pulses, and keeps a saturating or wrapping count with a sticky overflow and a snapshot port.
module toggle_event_counter #(
    parameter int unsigned CNT_W       = 8,
    parameter bit          SAT         = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q_in,
    input  logic             en,
    input  logic             clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [CNT_W-1:0] snap_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   q_prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       snap_q, snap_d;
    state_e                 state_q, state_d;
    logic                   q_s;
    logic                   edge_det;

    assign q_s      = sync_q[SYNC_STAGES-1];
    assign edge_det = q_s ^ q_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            q_prev_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            snap_q   <= '0;
            state_q  <= IDLE;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], q_in};
            q_prev_q <= q_s;
            rise_q   <= q_s & ~q_prev_q;
            fall_q   <= ~q_s & q_prev_q;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            snap_q   <= snap_d;
            state_q  <= state_d;
        end
    end

    // Counts on the same edge that registers the pulse; clear wins over a coincident edge.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (edge_det && en) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
                cnt_d = SAT ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        snap_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    snap_d  = cnt_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                snap_valid = 1'b1;
                if (snap_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign cnt        = cnt_q;
    assign ovf        = ovf_q;
    assign snap_cnt   = snap_q;

endmodule
